// File: rtl/bsb_pipe.sv
// bsb_pipe: pipelined multi-channel barrel shifter, one stage per shift-amount bit, valid/ready handshake.
// Optional feature macro BSB_PIPE_SAT_EN: left arithmetic shifts saturate and report out_sat.
module bsb_pipe #(
  parameter int N_CH = 8,
  parameter int W    = 10,
  parameter int SH_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SH_W-1:0]   in_amt,
  input  logic              in_dir,
  input  logic              in_arith,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_sat
);
  localparam int DW = N_CH * W;

  logic            v_reg     [SH_W];
  logic [DW-1:0]   data_reg  [SH_W];
  logic [SH_W-1:0] amt_reg   [SH_W];
  logic            dir_reg   [SH_W];
  logic            arith_reg [SH_W];

  logic            src_v     [SH_W];
  logic [DW-1:0]   src_data  [SH_W];
  logic [SH_W-1:0] src_amt   [SH_W];
  logic            src_dir   [SH_W];
  logic            src_arith [SH_W];
  logic [DW-1:0]   data_next [SH_W];
  logic [SH_W-1:0] load;

`ifdef BSB_PIPE_SAT_EN
  logic [N_CH-1:0] sat_reg  [SH_W];
  logic [N_CH-1:0] src_sat  [SH_W];
  logic [N_CH-1:0] sat_next [SH_W];
`endif

  // Ready ripples back from the output: a stage may load if it is empty or its successor loads.
  always_comb begin
    load = '0;
    load[SH_W-1] = !v_reg[SH_W-1] || out_ready;
    for (int k = SH_W - 2; k >= 0; k--) begin
      load[k] = !v_reg[k] || load[k+1];
    end
  end

  for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
    localparam int SH = 2 ** gi;

    if (gi == 0) begin : g_src_in
      assign src_v[gi]     = in_valid;
      assign src_data[gi]  = in_data;
      assign src_amt[gi]   = in_amt;
      assign src_dir[gi]   = in_dir;
      assign src_arith[gi] = in_arith;
`ifdef BSB_PIPE_SAT_EN
      assign src_sat[gi]   = '0;
`endif
    end else begin : g_src_reg
      assign src_v[gi]     = v_reg[gi-1];
      assign src_data[gi]  = data_reg[gi-1];
      assign src_amt[gi]   = amt_reg[gi-1];
      assign src_dir[gi]   = dir_reg[gi-1];
      assign src_arith[gi] = arith_reg[gi-1];
`ifdef BSB_PIPE_SAT_EN
      assign src_sat[gi]   = sat_reg[gi-1];
`endif
    end

    for (genvar ci = 0; ci < N_CH; ci++) begin : g_ch
      logic [W-1:0]        x;
      logic [W-1:0]        shl;
      logic [W-1:0]        shr_l;
      logic signed [W-1:0] shr_a;
      logic [W-1:0]        res;

      assign x     = src_data[gi][ci*W +: W];
      assign shl   = x << SH;
      assign shr_l = x >> SH;
      assign shr_a = $signed(x) >>> SH;

`ifdef BSB_PIPE_SAT_EN
      logic ovf;
      logic clamp;
      // Overflow iff shifting back does not recover the value: some discarded bit or the new MSB differs from the sign.
      assign ovf   = ($signed(shl) >>> SH) != $signed(x);
      assign clamp = src_amt[gi][0] && !src_dir[gi] && src_arith[gi] && ovf;
      assign sat_next[gi][ci] = src_sat[gi][ci] || clamp;
`endif

      always_comb begin
        res = x;
        if (src_amt[gi][0]) begin
          if (!src_dir[gi]) begin
            res = shl;
          end else if (src_arith[gi]) begin
            res = shr_a;
          end else begin
            res = shr_l;
          end
        end
`ifdef BSB_PIPE_SAT_EN
        // A clamped value keeps its sign, so the current MSB is still the original sign in later stages.
        if (clamp) begin
          res = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
      end

      assign data_next[gi][ci*W +: W] = res;
    end

    // Payload only moves with a valid beat, so idle input garbage never enters the pipe.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg[gi]     <= 1'b0;
        data_reg[gi]  <= '0;
        amt_reg[gi]   <= '0;
        dir_reg[gi]   <= 1'b0;
        arith_reg[gi] <= 1'b0;
`ifdef BSB_PIPE_SAT_EN
        sat_reg[gi]   <= '0;
`endif
      end else if (load[gi]) begin
        v_reg[gi] <= src_v[gi];
        if (src_v[gi]) begin
          data_reg[gi]  <= data_next[gi];
          amt_reg[gi]   <= src_amt[gi] >> 1;
          dir_reg[gi]   <= src_dir[gi];
          arith_reg[gi] <= src_arith[gi];
`ifdef BSB_PIPE_SAT_EN
          sat_reg[gi]   <= sat_next[gi];
`endif
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v_reg[SH_W-1];
  assign out_data  = data_reg[SH_W-1];

`ifdef BSB_PIPE_SAT_EN
  assign out_sat = sat_reg[SH_W-1];
`else
  assign out_sat = '0;
`endif

  // The last stage's control copies have no consumer.
  logic unused_tail;
  assign unused_tail = &{1'b0, amt_reg[SH_W-1], dir_reg[SH_W-1], arith_reg[SH_W-1]};

endmodule

// File: tb/tb_bsb_pipe.sv
// Testbench for bsb_pipe: directed cases plus randomized traffic checked against an arithmetic
// shift model and a scoreboard queue of accepted beats.
module tb_bsb_pipe;
  localparam int N_CH  = 8;
  localparam int W     = 10;
  localparam int SH_W  = 3;
  localparam int DEPTH = SH_W;
  localparam int DW    = N_CH * W;
`ifdef BSB_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SH_W-1:0] in_amt;
  logic            in_dir;
  logic            in_arith;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [N_CH-1:0] out_sat;

  bsb_pipe #(.N_CH(N_CH), .W(W), .SH_W(SH_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_arith(in_arith),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   data;
    logic [N_CH-1:0] sat;
    int              cyc;
  } exp_t;

  exp_t            q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc = 0;
  int              n_out = 0;
  bit              chk_lat = 1'b0;
  bit              last_in_fire = 1'b0;
  bit              hold_pending = 1'b0;
  logic [DW-1:0]   held_data;
  logic [N_CH-1:0] held_sat;
  logic [DW-1:0]   last_out_data = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: per-channel integer arithmetic, value * 2^amt or floor(value / 2^amt).
  function automatic void model(input logic [DW-1:0] d, input int amt, input logic dr,
                                input logic ar, output logic [DW-1:0] r,
                                output logic [N_CH-1:0] s);
    int u, sv, res;
    int maxv = 2 ** (W - 1) - 1;
    int minv = -(2 ** (W - 1));
    r = '0;
    s = '0;
    for (int c = 0; c < N_CH; c++) begin
      u  = int'(d[c*W +: W]);
      sv = (ar && u > maxv) ? u - 2 ** W : u;
      if (!dr) begin
        res = sv * (2 ** amt);
        if (SAT_EN && ar && (res > maxv || res < minv)) begin
          s[c] = 1'b1;
          res  = (sv < 0) ? minv : maxv;
        end
      end else begin
        res = sv >>> amt;
      end
      r[c*W +: W] = res[W-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int c = 0; c < N_CH; c++) d[c*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic rand_beat();
    in_data  = rand_data();
    in_amt   = SH_W'($urandom_range(0, 2 ** SH_W - 1));
    in_dir   = 1'($urandom_range(0, 1));
    in_arith = 1'($urandom_range(0, 1));
  endtask

  // One clock cycle: inputs are already driven; observe settled outputs, update scoreboard, advance.
  task automatic tick();
    exp_t e;
    bit   exp_ov;
    #2;
    last_in_fire = 1'b0;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (cyc - q[0].cyc) >= DEPTH;
      check("in_ready", in_ready, (q.size() < DEPTH) || out_ready);
      check("out_valid", out_valid, exp_ov);
      if (hold_pending) begin
        check("hold_data", out_data, held_data);
        check("hold_sat", out_sat, held_sat);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("data", out_data, e.data);
        check("sat", out_sat, e.sat);
        if (chk_lat) check("latency", cyc - e.cyc, DEPTH);
        last_out_data = out_data;
        n_out++;
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_sat     = out_sat;
      if (in_valid && in_ready) begin
        model(in_data, int'(in_amt), in_dir, in_arith, e.data, e.sat);
        e.cyc = cyc;
        q.push_back(e);
        last_in_fire = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send1(input logic [DW-1:0] d, input logic [SH_W-1:0] a, input logic dr,
                       input logic ar);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    in_arith = ar;
    do begin
      tick();
      guard++;
    end while (!last_in_fire && guard < 50);
    check("send_accepted", last_in_fire, 1'b1);
    in_valid = 1'b0;
    rand_beat();
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drained", q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0]   d;
    logic [W-1:0]    e0, e1;
    logic [N_CH-1:0] es;
    int              base, t, sent;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_dir = 1'b0; in_arith = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, '0);
    check("reset_out_sat", out_sat, '0);
    check("reset_in_ready", in_ready, 1'b1);

    // Stream, then reset mid-stream for two cycles.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      tick();
    end
    rst = 1'b1;
    repeat (2) tick();
    q.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_out_data", out_data, '0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    chk_lat = 1'b1;
    send1(rand_data(), 3'd5, 1'b1, 1'b1);
    drain();

    // Left logical shifts.
    d = '0; d[9:0] = 10'h001;
    send1(d, 3'd3, 1'b0, 1'b0);
    drain();
    check("left_amt3_ch0", last_out_data[9:0], 10'h008);
    d = '0; d[19:10] = 10'h3FF;
    send1(d, 3'd7, 1'b0, 1'b0);
    drain();
    check("left_amt7_ch1", last_out_data[19:10], 10'h380);

    // Right shifts and amt = 0.
    d = '0; d[9:0] = 10'h200;
    send1(d, 3'd2, 1'b1, 1'b1);
    drain();
    check("right_arith_ch0", last_out_data[9:0], 10'h380);
    send1(d, 3'd2, 1'b1, 1'b0);
    drain();
    check("right_logic_ch0", last_out_data[9:0], 10'h080);
    send1(d, 3'd0, 1'b1, 1'b1);
    drain();
    check("amt0_ch0", last_out_data[9:0], 10'h200);

    // Left arithmetic overflow.
    d = '0; d[9:0] = 10'h0C0; d[19:10] = 10'h340;
    send1(d, 3'd2, 1'b0, 1'b1);
    drain();
    e0 = SAT_EN ? 10'h1FF : 10'h300;
    e1 = SAT_EN ? 10'h200 : 10'h100;
    es = SAT_EN ? 8'h03 : 8'h00;
    check("left_arith_ch0", last_out_data[9:0], e0);
    check("left_arith_ch1", last_out_data[19:10], e1);
    check("left_arith_sat", dut.out_sat, es);

    // Ten back-to-back beats with out_ready low on cycles 4-8.
    chk_lat = 1'b0;
    base = n_out; t = 0; sent = 0;
    rand_beat();
    while ((n_out - base) < 10 && t < 80) begin
      out_ready = !(t >= 4 && t <= 8);
      in_valid  = (sent < 10);
      #1;
      if (t >= 4 && t <= 8) check("bp_in_ready_full", in_ready, 1'b0);
      if (t >= 9) check("bp_no_gap", out_valid, 1'b1);
      tick();
      if (last_in_fire) begin
        sent++;
        rand_beat();
      end
      t++;
    end
    check("bp_count", n_out - base, 10);
    drain();

    // Full-rate random stream.
    base = n_out;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_beat();
      tick();
    end
    drain();
    check("stream_count", n_out - base, 1000);

    // Random valid and backpressure; idle cycles carry garbage payload.
    for (int i = 0; i < 1500; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
